// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Predicts in the fetch stage, trains from memory-stage resolution, and reports mispredicts.
module branch_predictor_btb #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_WIDTH  = 2,
    parameter int MODE       = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] F_PC,
    output logic                  F_PredTaken,
    output logic [DATA_WIDTH-1:0] F_PredTarget,
    input  logic                  M_Update,
    input  logic [DATA_WIDTH-1:0] M_PC,
    input  logic                  M_IsJump,
    input  logic                  M_Taken,
    input  logic [DATA_WIDTH-1:0] M_Target,
    input  logic                  M_PredTaken,
    input  logic [DATA_WIDTH-1:0] M_PredTarget,
    input  logic                  Inv,
    output logic                  M_Mispredict,
    output logic [DATA_WIDTH-1:0] M_RedirectPC,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  MispredCount
);

    localparam int IDX       = $clog2(ENTRIES);
    localparam int TAG_WIDTH = DATA_WIDTH - IDX - 2;

    localparam logic [CTR_WIDTH-1:0]  CTR_MAX     = '1;
    localparam logic [CTR_WIDTH-1:0]  CTR_WEAK_T  = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
    localparam logic [CTR_WIDTH-1:0]  CTR_WEAK_NT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;
    localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(4);

    logic                  valid   [ENTRIES];
    logic [TAG_WIDTH-1:0]  tags    [ENTRIES];
    logic [DATA_WIDTH-1:0] targets [ENTRIES];
    logic                  jumps   [ENTRIES];
    logic [CTR_WIDTH-1:0]  ctrs    [ENTRIES];

    logic [IDX-1:0]        f_idx;
    logic [TAG_WIDTH-1:0]  f_tag;
    logic                  f_hit;
    logic                  f_dir_taken;

    logic [IDX-1:0]        m_idx;
    logic [TAG_WIDTH-1:0]  m_tag;
    logic                  m_hit;
    logic                  m_target_wrong;
    logic [CTR_WIDTH-1:0]  m_ctr_next;

    // Instructions are word aligned, so the low PC bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{F_PC[1:0], M_PC[1:0]};

    assign f_idx       = F_PC[IDX+1:2];
    assign f_tag       = F_PC[DATA_WIDTH-1:IDX+2];
    assign f_hit       = valid[f_idx] && (tags[f_idx] == f_tag);
    assign f_dir_taken = (MODE == 1) && ctrs[f_idx][CTR_WIDTH-1];

    assign F_PredTaken  = f_hit && (jumps[f_idx] || f_dir_taken);
    assign F_PredTarget = F_PredTaken ? targets[f_idx] : F_PC + PC_STEP;

    assign m_idx = M_PC[IDX+1:2];
    assign m_tag = M_PC[DATA_WIDTH-1:IDX+2];
    assign m_hit = valid[m_idx] && (tags[m_idx] == m_tag);

    assign m_target_wrong = M_Taken && M_PredTaken && (M_Target != M_PredTarget);
    assign M_Mispredict   = M_Update && ((M_Taken != M_PredTaken) || m_target_wrong);
    assign M_RedirectPC   = !M_Update ? '0 : (M_Taken ? M_Target : M_PC + PC_STEP);

    always_comb begin
        m_ctr_next = ctrs[m_idx];
        if (M_Taken && (ctrs[m_idx] != CTR_MAX)) begin
            m_ctr_next = ctrs[m_idx] + CTR_WIDTH'(1);
        end else if (!M_Taken && (ctrs[m_idx] != '0)) begin
            m_ctr_next = ctrs[m_idx] - CTR_WIDTH'(1);
        end
    end

    // Invalidation takes priority over any same-cycle training or allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tags[i]    <= '0;
                targets[i] <= '0;
                jumps[i]   <= 1'b0;
                ctrs[i]    <= CTR_WEAK_NT;
            end
        end else if (Inv) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
            end
        end else if (M_Update) begin
            if (m_hit) begin
                if (M_Taken) begin
                    targets[m_idx] <= M_Target;
                end
                jumps[m_idx] <= M_IsJump;
                ctrs[m_idx]  <= m_ctr_next;
            end else if (M_Taken) begin
                valid[m_idx]   <= 1'b1;
                tags[m_idx]    <= m_tag;
                targets[m_idx] <= M_Target;
                jumps[m_idx]   <= M_IsJump;
                ctrs[m_idx]    <= CTR_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BranchCount  <= '0;
            MispredCount <= '0;
        end else begin
            if (M_Update && (BranchCount != CNT_MAX)) begin
                BranchCount <= BranchCount + CNT_WIDTH'(1);
            end
            if (M_Mispredict && (MispredCount != CNT_MAX)) begin
                MispredCount <= MispredCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: a bimodal instance driven from a vector table,
// plus a MODE=0 instance with narrow counters for jump-only prediction and saturation.
module tb_branch_predictor_btb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        f_pc_in;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        m_update;
    logic [31:0] m_pc;
    logic        m_is_jump;
    logic        m_taken;
    logic [31:0] m_target;
    logic        m_pred_taken;
    logic [31:0] m_pred_target;
    logic        inv;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count;
    logic [15:0] mispred_count;

    logic [31:0] z_f_pc;
    logic        z_pred_taken;
    logic [31:0] z_pred_target;
    logic        z_update;
    logic [31:0] z_pc;
    logic        z_is_jump;
    logic        z_taken;
    logic [31:0] z_target;
    logic        z_p_taken;
    logic [31:0] z_p_target;
    logic        z_inv;
    logic        z_mispredict;
    logic [31:0] z_redirect_pc;
    logic [2:0]  z_branch_count;
    logic [2:0]  z_mispred_count;

    int checks;
    int failures;

    branch_predictor_btb dut (
        .clk          (clk),
        .rst          (rst),
        .F_PC         (f_pc),
        .F_PredTaken  (pred_taken),
        .F_PredTarget (pred_target),
        .M_Update     (m_update),
        .M_PC         (m_pc),
        .M_IsJump     (m_is_jump),
        .M_Taken      (m_taken),
        .M_Target     (m_target),
        .M_PredTaken  (m_pred_taken),
        .M_PredTarget (m_pred_target),
        .Inv          (inv),
        .M_Mispredict (mispredict),
        .M_RedirectPC (redirect_pc),
        .BranchCount  (branch_count),
        .MispredCount (mispred_count)
    );

    branch_predictor_btb #(
        .MODE      (0),
        .CNT_WIDTH (3)
    ) dut_static (
        .clk          (clk),
        .rst          (rst),
        .F_PC         (z_f_pc),
        .F_PredTaken  (z_pred_taken),
        .F_PredTarget (z_pred_target),
        .M_Update     (z_update),
        .M_PC         (z_pc),
        .M_IsJump     (z_is_jump),
        .M_Taken      (z_taken),
        .M_Target     (z_target),
        .M_PredTaken  (z_p_taken),
        .M_PredTarget (z_p_target),
        .Inv          (z_inv),
        .M_Mispredict (z_mispredict),
        .M_RedirectPC (z_redirect_pc),
        .BranchCount  (z_branch_count),
        .MispredCount (z_mispred_count)
    );

    typedef struct packed {
        logic [31:0] f_pc;
        logic        upd;
        logic [31:0] pc;
        logic        jump;
        logic        taken;
        logic [31:0] tgt;
        logic        ptaken;
        logic [31:0] ptgt;
        logic        inv;
        logic        exp_pt;
        logic [31:0] exp_tgt;
        logic        exp_misp;
        logic [31:0] exp_redir;
        logic [15:0] exp_bc;
        logic [15:0] exp_mc;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic [31:0] fpc, input logic upd, input logic [31:0] pc, input logic jump,
        input logic taken, input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
        input logic iv, input logic e_pt, input logic [31:0] e_tgt, input logic e_misp,
        input logic [31:0] e_redir, input logic [15:0] e_bc, input logic [15:0] e_mc);
        vec_t v;
        v = '{fpc, upd, pc, jump, taken, tgt, ptaken, ptgt, iv, e_pt, e_tgt, e_misp, e_redir, e_bc, e_mc};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        f_pc          = v.f_pc;
        m_update      = v.upd;
        m_pc          = v.pc;
        m_is_jump     = v.jump;
        m_taken       = v.taken;
        m_target      = v.tgt;
        m_pred_taken  = v.ptaken;
        m_pred_target = v.ptgt;
        inv           = v.inv;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic z_drive(input logic [31:0] pc, input logic jump, input logic taken,
                           input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        @(negedge clk);
        z_f_pc     = pc;
        z_update   = 1'b1;
        z_pc       = pc;
        z_is_jump  = jump;
        z_taken    = taken;
        z_target   = tgt;
        z_p_taken  = ptaken;
        z_p_target = ptgt;
        #1;
    endtask

    task automatic z_idle(input logic [31:0] fpc);
        @(negedge clk);
        z_f_pc   = fpc;
        z_update = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        f_pc_in  = 1'b0;
        rst = 1'b0;
        f_pc = 32'h100; m_update = 0; m_pc = 0; m_is_jump = 0; m_taken = 0;
        m_target = 0; m_pred_taken = 0; m_pred_target = 0; inv = 0;
        z_f_pc = 32'h100; z_update = 0; z_pc = 0; z_is_jump = 0; z_taken = 0;
        z_target = 0; z_p_taken = 0; z_p_target = 0; z_inv = 0;

        // Bimodal training, hysteresis, aliasing, not-taken miss, jumps and invalidation.
        vecs[0]  = mk(32'h100, 0, 0,       0, 0, 0,       0, 0,       0, 0, 32'h104, 0, 0,       0,  0);
        vecs[1]  = mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 0, 32'h104, 1, 32'h80,  0,  0);
        vecs[2]  = mk(32'h100, 0, 0,       0, 0, 0,       0, 0,       0, 1, 32'h80,  0, 0,       1,  1);
        vecs[3]  = mk(32'h100, 1, 32'h100, 0, 0, 0,       1, 32'h80,  0, 1, 32'h80,  1, 32'h104, 1,  1);
        vecs[4]  = mk(32'h100, 0, 0,       0, 0, 0,       0, 0,       0, 0, 32'h104, 0, 0,       2,  2);
        vecs[5]  = mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 0, 32'h104, 1, 32'h80,  2,  2);
        vecs[6]  = mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  1, 32'h80,  0, 1, 32'h80,  0, 32'h80,  3,  3);
        vecs[7]  = mk(32'h100, 1, 32'h100, 0, 0, 0,       1, 32'h80,  0, 1, 32'h80,  1, 32'h104, 4,  3);
        vecs[8]  = mk(32'h100, 0, 0,       0, 0, 0,       0, 0,       0, 1, 32'h80,  0, 0,       5,  4);
        vecs[9]  = mk(32'h140, 1, 32'h140, 0, 1, 32'h200, 0, 32'h144, 0, 0, 32'h144, 1, 32'h200, 5,  4);
        vecs[10] = mk(32'h100, 0, 0,       0, 0, 0,       0, 0,       0, 0, 32'h104, 0, 0,       6,  5);
        vecs[11] = mk(32'h140, 0, 0,       0, 0, 0,       0, 0,       0, 1, 32'h200, 0, 0,       6,  5);
        vecs[12] = mk(32'h104, 1, 32'h104, 0, 0, 0,       0, 32'h108, 0, 0, 32'h108, 0, 32'h108, 6,  5);
        vecs[13] = mk(32'h104, 0, 0,       0, 0, 0,       0, 0,       0, 0, 32'h108, 0, 0,       7,  5);
        vecs[14] = mk(32'h200, 1, 32'h200, 1, 1, 32'h400, 0, 32'h204, 0, 0, 32'h204, 1, 32'h400, 7,  5);
        vecs[15] = mk(32'h200, 0, 0,       0, 0, 0,       0, 0,       0, 1, 32'h400, 0, 0,       8,  6);
        vecs[16] = mk(32'h200, 1, 32'h200, 1, 1, 32'h400, 1, 32'h404, 0, 1, 32'h400, 1, 32'h400, 8,  6);
        vecs[17] = mk(32'h200, 1, 32'h300, 0, 1, 32'h500, 0, 32'h304, 1, 1, 32'h400, 1, 32'h500, 9,  7);
        vecs[18] = mk(32'h200, 0, 0,       0, 0, 0,       0, 0,       0, 0, 32'h204, 0, 0,       10, 8);
        vecs[19] = mk(32'h300, 0, 0,       0, 0, 0,       0, 0,       0, 0, 32'h304, 0, 0,       10, 8);

        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].exp_pt));
            checkOutput($sformatf("v%0d pred_target", i), pred_target, vecs[i].exp_tgt);
            checkOutput($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].exp_misp));
            checkOutput($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].exp_redir);
            checkOutput($sformatf("v%0d branch_count", i), 32'(branch_count), 32'(vecs[i].exp_bc));
            checkOutput($sformatf("v%0d mispred_count", i), 32'(mispred_count), 32'(vecs[i].exp_mc));
        end

        // Allocation works again after invalidation.
        applyStimulus(mk(32'h300, 1, 32'h300, 0, 1, 32'h500, 0, 32'h304, 0, 0, 32'h304, 1, 32'h500, 10, 8));
        checkOutput("realloc mispredict", 32'(mispredict), 32'd1);
        applyStimulus(mk(32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("realloc pred_taken", 32'(pred_taken), 32'd1);
        checkOutput("realloc pred_target", pred_target, 32'h500);
        checkOutput("realloc branch_count", 32'(branch_count), 32'd11);
        checkOutput("realloc mispred_count", 32'(mispred_count), 32'd9);

        // Static-not-taken instance: only jumps redirect, counters saturate at 7.
        z_drive(32'h100, 0, 1, 32'h80, 0, 32'h104);
        checkOutput("z taken miss mispredict", 32'(z_mispredict), 32'd1);
        checkOutput("z taken miss redirect", z_redirect_pc, 32'h80);
        z_idle(32'h100);
        checkOutput("z branch no predict", 32'(z_pred_taken), 32'd0);
        checkOutput("z branch target", z_pred_target, 32'h104);
        checkOutput("z branch_count 1", 32'(z_branch_count), 32'd1);
        z_drive(32'h200, 1, 1, 32'h400, 0, 32'h204);
        checkOutput("z jal mispredict", 32'(z_mispredict), 32'd1);
        z_idle(32'h200);
        checkOutput("z jal pred_taken", 32'(z_pred_taken), 32'd1);
        checkOutput("z jal pred_target", z_pred_target, 32'h400);
        z_drive(32'h200, 1, 1, 32'h400, 1, 32'h404);
        checkOutput("z wrong target mispredict", 32'(z_mispredict), 32'd1);
        checkOutput("z wrong target redirect", z_redirect_pc, 32'h400);
        for (int i = 0; i < 6; i++) begin
            z_drive(32'h200, 1, 1, 32'h400, 1, 32'h400);
            checkOutput($sformatf("z correct jal %0d mispredict", i), 32'(z_mispredict), 32'd0);
        end
        z_idle(32'h200);
        checkOutput("z branch_count saturated", 32'(z_branch_count), 32'd7);
        checkOutput("z mispred_count 3", 32'(z_mispred_count), 32'd3);
        for (int i = 0; i < 5; i++) begin
            z_drive(32'h104, 0, 1, 32'h90, 0, 32'h108);
            checkOutput($sformatf("z train %0d mispredict", i), 32'(z_mispredict), 32'd1);
        end
        z_idle(32'h104);
        checkOutput("z trained branch no predict", 32'(z_pred_taken), 32'd0);
        checkOutput("z trained branch target", z_pred_target, 32'h108);
        checkOutput("z mispred_count saturated", 32'(z_mispred_count), 32'd7);
        checkOutput("z branch_count held", 32'(z_branch_count), 32'd7);

        // Asynchronous reset mid-cycle, then updates ignored while held in reset.
        #1 rst = 1'b0;
        #1;
        checkOutput("async rst branch_count", 32'(branch_count), 32'd0);
        checkOutput("async rst mispred_count", 32'(mispred_count), 32'd0);
        checkOutput("async rst pred_taken", 32'(pred_taken), 32'd0);
        checkOutput("async rst pred_target", pred_target, 32'h304);
        checkOutput("async rst z_branch_count", 32'(z_branch_count), 32'd0);
        checkOutput("async rst z_mispred_count", 32'(z_mispred_count), 32'd0);
        m_update = 1; m_pc = 32'h300; m_is_jump = 0; m_taken = 1;
        m_target = 32'h500; m_pred_taken = 0; m_pred_target = 32'h304; inv = 0;
        #1;
        checkOutput("in rst mispredict", 32'(mispredict), 32'd1);
        checkOutput("in rst redirect", redirect_pc, 32'h500);
        @(negedge clk);
        #1;
        checkOutput("in rst branch_count held", 32'(branch_count), 32'd0);
        rst = 1'b1;
        m_update = 0;
        @(negedge clk);
        #1;
        checkOutput("post rst no alloc", 32'(pred_taken), 32'd0);
        checkOutput("post rst target", pred_target, 32'h304);
        applyStimulus(mk(32'h300, 1, 32'h300, 0, 1, 32'h500, 0, 32'h304, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("post rst alloc pred_taken", 32'(pred_taken), 32'd1);
        checkOutput("post rst branch_count", 32'(branch_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
